fib_seq_ctrl: RTL and testbench
===============================

# fib_seq_ctrl

Parametrised sequence-generation controller for the register-file/ALU datapath. It drives the register file selects, ALU opcode and buffer controls to load two programmable seeds and then compute a run-time-selected number of recurrence terms. Each term is R[n] = R[n-1] op R[n-2], with op being ADD (Fibonacci) or SUB (difference sequence). It adds a start/busy/done handshake and register-index wrap-around, and it replaces the fixed 16-step seed-7/13 controller.

## Interface
- DATA_W, 16: datapath width; width of seeds and initialR.
- NUM_REGS, 16: register file depth; power of two, at least 4.
- RA_W, $clog2(NUM_REGS): register select width (derived, not overridable).
- TERM_W, 8: width of num_terms.

Ports:
- clk  in  1: clock.
- reset  in  1: reset, asynchronous, active-high.
- start  in  1: begin a run. Sampled only in IDLE.
- mode  in  1: 0 = ADD recurrence, 1 = SUB recurrence. Latched on start.
- seed0  in  DATA_W: first term. Latched on start.
- seed1  in  DATA_W: second term. Latched on start.
- num_terms  in  TERM_W: total terms to write, including seeds. Latched on start.
- initialR  out  DATA_W: immediate value routed to the register write path.
- regWrite  out  RA_W: write register select.
- regRead1  out  RA_W: read port 1 select, R[n-1].
- regRead2  out  RA_W: read port 2 select, R[n-2].
- ALUOp  out  4: opcode from the shared opcode include.
- buffCtrl  out  4: buffer control. IMM_PATH = 4'b0001, ALU_PATH = 4'b1110, NONE = 4'b0000.
- regWriteEn  out  1: register write enable.
- busy  out  1: run in progress.
- done  out  1: one-cycle pulse when the final term has been written.

## Operation
- States: IDLE, SEED0, SEED1, RUN, DONE.
- IDLE:
  - All datapath outputs are 0; regWriteEn = 0; buffCtrl = NONE.
  - On start = 1, latch mode, seeds and num_terms, and clear widx.
  - Next state: DONE if num_terms = 0, otherwise SEED0.
- SEED0:
  - initialR = seed0, regWrite = widx (0), ALUOp = AND, buffCtrl = IMM_PATH, regWriteEn = 1.
  - Next state: DONE if num_terms = 1, otherwise SEED1.
- SEED1:
  - Same as SEED0 but with seed1 and widx = 1.
  - Next state: DONE if num_terms = 2, otherwise RUN.
- RUN, one term per cycle:
  - initialR = 0; regWrite = widx.
  - regRead1 = widx-1 and regRead2 = widx-2, both mod NUM_REGS.
  - ALUOp = ADD when mode = 0, SUB when mode = 1; buffCtrl = ALU_PATH; regWriteEn = 1.
  - Go to DONE after the cycle that writes term num_terms-1.
- DONE: regWriteEn = 0, done = 1 for exactly one cycle, then return to IDLE.
- widx (RA_W bits) increments after every write and wraps NUM_REGS-1 → 0. Once more than NUM_REGS terms are requested, older terms are overwritten; read selects wrap the same way.
- Arithmetic is performed by the ALU modulo 2^DATA_W. This block does no arithmetic on data.
- busy = 1 in SEED0, SEED1 and RUN; 0 in IDLE and DONE.
- start while busy or in DONE is ignored, and latched parameters do not change mid-run.
- Input changes to mode, seeds or num_terms after the start cycle have no effect.

## Timing
- Moore outputs: decoded from registered state, widx and the term counter. They are valid for the whole cycle the state is held.
- start sampled at edge E0 → SEED0 outputs during cycle E0..E1. Term k is presented during cycle k, and the register file captures it at the following edge.
- The done pulse occurs in cycle num_terms (counting SEED0 as cycle 0). busy is high for num_terms cycles.
- A new start is accepted in IDLE, i.e. one cycle after the done pulse at the earliest.
- Reset:
  - Asynchronous; takes effect immediately and returns to IDLE.
  - All outputs go to 0 and the latched registers clear.
  - Reset mid-run abandons the run with no done pulse. Register file contents are not restored.

## Structure
- Shared include (with the ALU opcode file):
  - the ADD/SUB/AND opcode constants;
  - the buffCtrl encodings IMM_PATH, ALU_PATH, NONE;
  - the state encodings.
- One sub-module is natural: fib_idx_ctr, a wrap-around RA_W index counter with clear/increment. It is used for widx. The read selects are derived by modular subtraction.
- Term counter: TERM_W bits inside the FSM.

## Test plan
- Defaults, seeds 7/13, num_terms 16, mode 0:
  - 16 writes to R0..R15;
  - read pairs (1,0) through (14,13);
  - done in cycle 16;
  - a register file model holds R15 = 10569.
- Wrap, num_terms 20:
  - the 17th write targets R0 with regRead1 = 15, regRead2 = 14, and R0 = 17101;
  - writes continue through R3;
  - busy is high for exactly 20 cycles.
- mode 1, seeds 5/3, num_terms 5:
  - ALUOp = SUB;
  - R2 = 16'hFFFE, R3 = 16'hFFFB, R4 = 16'hFFFD.
- num_terms 0 → no regWriteEn, done on the next cycle. num_terms 1 → a single seed0 write to R0, then done. num_terms 2 → two seed writes, then done.
- start pulsed while busy, with changed seeds → ignored; the run completes with the original seeds and only one done pulse occurs.
- reset asserted mid-RUN between clock edges → outputs zero immediately, no done pulse, and a new start then runs cleanly from R0.

Source files
------------

// File: rtl/fib_seq_ctrl_pkg.sv
// rtl/fib_seq_ctrl_pkg.sv - shared opcode, buffer-control and state encodings
package fib_seq_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [3:0] BUFF_NONE = 4'b0000;
    localparam logic [3:0] IMM_PATH  = 4'b0001;
    localparam logic [3:0] ALU_PATH  = 4'b1110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED0,
        ST_SEED1,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fib_seq_ctrl_if.sv
// rtl/fib_seq_ctrl_if.sv - start/parameter inputs and datapath control outputs
interface fib_seq_ctrl_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int TERM_W   = 8
);
    localparam int RA_W = $clog2(NUM_REGS);

    logic              start;
    logic              mode;
    logic [DATA_W-1:0] seed0;
    logic [DATA_W-1:0] seed1;
    logic [TERM_W-1:0] num_terms;

    logic [DATA_W-1:0] initialR;
    logic [RA_W-1:0]   regWrite;
    logic [RA_W-1:0]   regRead1;
    logic [RA_W-1:0]   regRead2;
    logic [3:0]        ALUOp;
    logic [3:0]        buffCtrl;
    logic              regWriteEn;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, seed0, seed1, num_terms,
        input  initialR, regWrite, regRead1, regRead2, ALUOp, buffCtrl,
               regWriteEn, busy, done
    );

    modport slave (
        input  start, mode, seed0, seed1, num_terms,
        output initialR, regWrite, regRead1, regRead2, ALUOp, buffCtrl,
               regWriteEn, busy, done
    );
endinterface

// File: rtl/fib_idx_ctr.sv
// rtl/fib_idx_ctr.sv - wrap-around register index counter with clear/increment
module fib_idx_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] idx
);
    // NUM_REGS is a power of two, so natural overflow gives the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idx <= '0;
        else if (clr)
            idx <= '0;
        else if (inc)
            idx <= idx + W'(1);
    end
endmodule

// File: rtl/fib_seq_ctrl.sv
// rtl/fib_seq_ctrl.sv - seed/recurrence sequencing controller for the regfile/ALU datapath
module fib_seq_ctrl
    import fib_seq_ctrl_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int TERM_W   = 8
) (
    input  logic          clk,
    input  logic          reset,
    fib_seq_ctrl_if.slave bus
);
    localparam int RA_W = $clog2(NUM_REGS);

    state_t            state, state_nxt;
    logic              mode_q;
    logic [DATA_W-1:0] seed0_q, seed1_q;
    logic [TERM_W-1:0] nterms_q, cnt_q;
    logic [RA_W-1:0]   widx;
    logic              launch, write_en, last;

    logic [DATA_W-1:0] initial_r;
    logic [RA_W-1:0]   rd1, rd2;
    logic [3:0]        alu_op, buff_ctrl;
    logic              busy, done;

    assign launch   = (state == ST_IDLE) && bus.start;
    assign write_en = (state == ST_SEED0) || (state == ST_SEED1) || (state == ST_RUN);
    // cnt_q is the index of the term being written this cycle.
    assign last     = (cnt_q == nterms_q - TERM_W'(1));

    fib_idx_ctr #(.W(RA_W)) u_widx (
        .clk   (clk),
        .reset (reset),
        .clr   (launch),
        .inc   (write_en),
        .idx   (widx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            mode_q   <= 1'b0;
            seed0_q  <= '0;
            seed1_q  <= '0;
            nterms_q <= '0;
            cnt_q    <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                mode_q   <= bus.mode;
                seed0_q  <= bus.seed0;
                seed1_q  <= bus.seed1;
                nterms_q <= bus.num_terms;
                cnt_q    <= '0;
            end else if (write_en) begin
                cnt_q <= cnt_q + TERM_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        initial_r = '0;
        rd1       = '0;
        rd2       = '0;
        alu_op    = 4'b0000;
        buff_ctrl = BUFF_NONE;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start)
                    state_nxt = (bus.num_terms == '0) ? ST_DONE : ST_SEED0;
            end
            ST_SEED0, ST_SEED1: begin
                initial_r = (state == ST_SEED0) ? seed0_q : seed1_q;
                alu_op    = ALU_AND;
                buff_ctrl = IMM_PATH;
                busy      = 1'b1;
                if (last)
                    state_nxt = ST_DONE;
                else
                    state_nxt = (state == ST_SEED0) ? ST_SEED1 : ST_RUN;
            end
            ST_RUN: begin
                rd1       = widx - RA_W'(1);
                rd2       = widx - RA_W'(2);
                alu_op    = mode_q ? ALU_SUB : ALU_ADD;
                buff_ctrl = ALU_PATH;
                busy      = 1'b1;
                if (last)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.initialR   = initial_r;
    assign bus.regWrite   = write_en ? widx : '0;
    assign bus.regRead1   = rd1;
    assign bus.regRead2   = rd2;
    assign bus.ALUOp      = alu_op;
    assign bus.buffCtrl   = buff_ctrl;
    assign bus.regWriteEn = write_en;
    assign bus.busy       = busy;
    assign bus.done       = done;
endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb/tb_fib_seq_ctrl.sv - scoreboard bench for fib_seq_ctrl with a register file/ALU model
module tb_fib_seq_ctrl;
    import fib_seq_ctrl_pkg::*;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;
    localparam int TERM_W   = 8;
    localparam int RA_W     = 4;

    typedef struct {
        logic [DATA_W-1:0] init;
        logic [RA_W-1:0]   wr;
        logic [RA_W-1:0]   r1;
        logic [RA_W-1:0]   r2;
        logic [3:0]        op;
        logic [3:0]        bc;
        logic              we;
        logic              busy;
        logic              done;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fib_seq_ctrl_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .TERM_W(TERM_W)) bus ();

    fib_seq_ctrl #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .TERM_W(TERM_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] rf [NUM_REGS];
    always @(posedge clk) begin
        if (!reset && bus.regWriteEn) begin
            if (bus.buffCtrl == IMM_PATH)
                rf[bus.regWrite] <= bus.initialR;
            else if (bus.ALUOp == ALU_ADD)
                rf[bus.regWrite] <= rf[bus.regRead1] + rf[bus.regRead2];
            else if (bus.ALUOp == ALU_SUB)
                rf[bus.regWrite] <= rf[bus.regRead1] - rf[bus.regRead2];
            else
                rf[bus.regWrite] <= 'x;
        end
    end

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t expq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(int k, int nt, bit m, logic [DATA_W-1:0] s0, logic [DATA_W-1:0] s1);
        exp_t e;
        e = '{default: '0};
        if (k < nt) begin
            e.we   = 1'b1;
            e.busy = 1'b1;
            e.wr   = RA_W'(k % NUM_REGS);
            if (k < 2) begin
                e.init = (k == 0) ? s0 : s1;
                e.op   = ALU_AND;
                e.bc   = IMM_PATH;
            end else begin
                e.r1 = RA_W'((k - 1) % NUM_REGS);
                e.r2 = RA_W'((k - 2) % NUM_REGS);
                e.op = m ? ALU_SUB : ALU_ADD;
                e.bc = ALU_PATH;
            end
        end else if (k == nt) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [DATA_W-1:0] term(int j, bit m, logic [DATA_W-1:0] s0, logic [DATA_W-1:0] s1);
        logic [DATA_W-1:0] a, b, c;
        a = s0;
        b = s1;
        if (j == 0) return s0;
        for (int i = 2; i <= j; i++) begin
            c = m ? (b - a) : (a + b);
            a = b;
            b = c;
        end
        return b;
    endfunction

    // poke >= 0 re-asserts start with different parameters at that cycle.
    task automatic run_seq(input int nt, input bit m, input logic [DATA_W-1:0] s0,
                           input logic [DATA_W-1:0] s1, input int poke, input string name);
        exp_t e;
        int   busy_cnt;
        int   j;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.seed0     = s0;
        bus.seed1     = s1;
        bus.num_terms = TERM_W'(nt);
        for (int k = 0; k < nt + 2; k++) expq.push_back(mk(k, nt, m, s0, s1));
        busy_cnt = 0;
        for (int k = 0; k < nt + 2; k++) begin
            @(negedge clk);
            e = expq.pop_front();
            chk($sformatf("%s c%0d we", name, k), 32'(bus.regWriteEn), 32'(e.we));
            chk($sformatf("%s c%0d busy", name, k), 32'(bus.busy), 32'(e.busy));
            chk($sformatf("%s c%0d done", name, k), 32'(bus.done), 32'(e.done));
            chk($sformatf("%s c%0d wr", name, k), 32'(bus.regWrite), 32'(e.wr));
            chk($sformatf("%s c%0d rd1", name, k), 32'(bus.regRead1), 32'(e.r1));
            chk($sformatf("%s c%0d rd2", name, k), 32'(bus.regRead2), 32'(e.r2));
            chk($sformatf("%s c%0d aluop", name, k), 32'(bus.ALUOp), 32'(e.op));
            chk($sformatf("%s c%0d buff", name, k), 32'(bus.buffCtrl), 32'(e.bc));
            chk($sformatf("%s c%0d initR", name, k), 32'(bus.initialR), 32'(e.init));
            busy_cnt += int'(bus.busy);
            bus.start     = (k == poke);
            bus.mode      = ~m;
            bus.seed0     = DATA_W'($urandom);
            bus.seed1     = DATA_W'($urandom);
            bus.num_terms = TERM_W'($urandom_range(1, 200));
        end
        bus.start = 1'b0;
        chk($sformatf("%s busy_cycles", name), 32'(busy_cnt), 32'(nt));
        for (int i = 0; i < nt && i < NUM_REGS; i++) begin
            j = i + ((nt - 1 - i) / NUM_REGS) * NUM_REGS;
            chk($sformatf("%s R%0d", name, i), 32'(rf[i]), 32'(term(j, m, s0, s1)));
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.seed0     = '0;
        bus.seed1     = '0;
        bus.num_terms = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst we", 32'(bus.regWriteEn), 32'd0);
        chk("rst buff", 32'(bus.buffCtrl), 32'(BUFF_NONE));
        reset = 1'b0;

        run_seq(16, 1'b0, 16'd7, 16'd13, -1, "fib16");
        chk("fib16 R15 const", 32'(rf[15]), 32'd10569);
        run_seq(20, 1'b0, 16'd7, 16'd13, -1, "wrap20");
        chk("wrap20 R0 const", 32'(rf[0]), 32'd17101);
        run_seq(5, 1'b1, 16'd5, 16'd3, -1, "sub5");
        chk("sub5 R2 const", 32'(rf[2]), 32'hFFFE);
        chk("sub5 R3 const", 32'(rf[3]), 32'hFFFB);
        chk("sub5 R4 const", 32'(rf[4]), 32'hFFFD);
        run_seq(0, 1'b0, 16'd9, 16'd9, -1, "nt0");
        run_seq(1, 1'b0, 16'd42, 16'd77, -1, "nt1");
        run_seq(2, 1'b1, 16'd100, 16'd200, -1, "nt2");
        run_seq(10, 1'b0, 16'd1, 16'd1, 4, "poke_busy");
        run_seq(3, 1'b0, 16'd2, 16'd3, 3, "poke_done");

        // Abandon a run mid-RUN with an asynchronous reset between edges.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.mode      = 1'b0;
        bus.seed0     = 16'd11;
        bus.seed1     = 16'd22;
        bus.num_terms = 8'd16;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst we", 32'(bus.regWriteEn), 32'd0);
        chk("async_rst busy", 32'(bus.busy), 32'd0);
        chk("async_rst wr", 32'(bus.regWrite), 32'd0);
        chk("async_rst buff", 32'(bus.buffCtrl), 32'd0);
        chk("async_rst aluop", 32'(bus.ALUOp), 32'd0);
        chk("async_rst rd1", 32'(bus.regRead1), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst c%0d done", k), 32'(bus.done), 32'd0);
            chk($sformatf("post_rst c%0d busy", k), 32'(bus.busy), 32'd0);
        end
        run_seq(16, 1'b0, 16'd4, 16'd9, -1, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
